// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the data-memory access unit.
package mem_access_unit_pkg;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // FSM state encodings
  localparam logic [1:0] MAU_IDLE = 2'd0;
  localparam logic [1:0] MAU_BUSY = 2'd1;
  localparam logic [1:0] MAU_DONE = 2'd2;

  function automatic logic ld_legal(input logic [2:0] t);
    case (t)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ld_legal = 1'b1;
      default:                             ld_legal = 1'b0;
    endcase
  endfunction

  function automatic logic st_legal(input logic [2:0] t);
    case (t)
      F3_SB, F3_SH, F3_SW: st_legal = 1'b1;
      default:             st_legal = 1'b0;
    endcase
  endfunction

  // funct3[1:0] is the access size for both loads and stores: 00 B, 01 H, 10 W
  function automatic logic size_aligned(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b00:   size_aligned = 1'b1;
      2'b01:   size_aligned = ~lane[0];
      2'b10:   size_aligned = (lane == 2'b00);
      default: size_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] st_strb(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b00:   st_strb = 4'b0001 << lane;
      2'b01:   st_strb = lane[1] ? 4'b1100 : 4'b0011;
      default: st_strb = 4'b1111;
    endcase
  endfunction

  // Replicate store data across lanes so the strobes alone pick the bytes
  function automatic logic [31:0] st_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   st_wdata = {4{d[7:0]}};
      2'b01:   st_wdata = {2{d[15:0]}};
      default: st_wdata = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Extracts and extends the addressed byte/half from a returned bus word.
module mem_access_unit_load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  load_type_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the lane byte and the half selected by lane[1]
  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Sign/zero extend according to the load type
  always_comb begin
    case (load_type_i)
      F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result_o = {24'h0, byte_sel};
      F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result_o = {16'h0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns one mem_read/mem_write into a word-aligned req/ack
// bus transaction, stalls the pipeline meanwhile, formats load data and
// reports misaligned/illegal accesses and ack timeouts.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        load_type,
  input  logic [2:0]        store_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              stall,
  output logic              misaligned,
  output logic              bus_error,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        ltype_q, ltype_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       ld_q, ld_d;
  logic              lv_q, lv_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;

  logic        request, legal, accept;
  logic [1:0]  sz;
  logic [31:0] fmt_data;

  // Exactly one of read/write is a request; both at once is illegal
  assign request = mem_read ^ mem_write;
  assign sz      = mem_read ? load_type[1:0] : store_type[1:0];
  assign legal   = mem_read ? ld_legal(load_type) : st_legal(store_type);
  assign accept  = request & legal & size_aligned(sz, addr[1:0]);

  assign stall = ((state_q == MAU_IDLE) & accept) | (state_q == MAU_BUSY);

  mem_access_unit_load_formatter u_fmt (
    .rdata_i     (bus_rdata),
    .load_type_i (ltype_q),
    .lane_i      (lane_q),
    .result_o    (fmt_data)
  );

  // Next-state: IDLE launches or rejects, BUSY waits for ack/timeout, DONE
  // spends one cycle so the still-present instruction cannot re-trigger
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    ltype_d = ltype_q;
    lane_d  = lane_q;
    ld_d    = ld_q;
    lv_d    = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      MAU_IDLE: begin
        if (accept) begin
          state_d = MAU_BUSY;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = {addr[ADDR_W-1:2], 2'b00};
          wstrb_d = mem_write ? st_strb(sz, addr[1:0]) : 4'b0000;
          wdata_d = mem_write ? st_wdata(sz, store_data) : 32'h0;
          ltype_d = load_type;
          lane_d  = addr[1:0];
        end else if (mem_read | mem_write) begin
          mis_d = 1'b1;
        end
      end
      MAU_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // Ack wins over an expiring count
        if (bus_ack) begin
          req_d   = 1'b0;
          state_d = MAU_DONE;
          if (!we_q) begin
            ld_d = fmt_data;
            lv_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          ld_d    = 32'h0;
          state_d = MAU_DONE;
        end
      end
      MAU_DONE: state_d = MAU_IDLE;
      default:  state_d = MAU_IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MAU_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0;
      ltype_q <= 3'b000;
      lane_q  <= 2'b00;
      ld_q    <= 32'h0;
      lv_q    <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      ltype_q <= ltype_d;
      lane_q  <= lane_d;
      ld_q    <= ld_d;
      lv_q    <= lv_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign bus_req    = req_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_wstrb  = wstrb_q;
  assign bus_wdata  = wdata_q;
  assign load_data  = ld_q;
  assign load_valid = lv_q;
  assign misaligned = mis_q;
  assign bus_error  = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, corner sequences, random loads
// and stores against a behavioural model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  load_type = 3'b0, store_type = 3'b0;
  logic [31:0] addr = 32'h0, store_data = 32'h0;
  logic [31:0] load_data;
  logic        load_valid, stall, misaligned, bus_error;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .load_type(load_type), .store_type(store_type), .addr(addr),
    .store_data(store_data), .load_data(load_data), .load_valid(load_valid),
    .stall(stall), .misaligned(misaligned), .bus_error(bus_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stall_c, req_c, lv_c, mis_c, err_c;
    logic [31:0] ld, baddr, wdata;
    logic        we;
    logic [3:0]  strb;
  } exp_t;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  lt, st;
    logic [31:0] addr, data, rdata;
    int          dly;   // ack on this BUSY cycle; 0 = never
    exp_t        e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] lt,
      input logic [2:0] st, input logic [31:0] a, input logic [31:0] d,
      input logic [31:0] rdat, input int dly, input int sc, input int rc, input int lv,
      input int mis, input int err, input logic [31:0] ld, input logic [31:0] ba,
      input logic we, input logic [3:0] strb, input logic [31:0] wd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.lt = lt; v.st = st; v.addr = a; v.data = d;
    v.rdata = rdat; v.dly = dly;
    v.e.stall_c = sc; v.e.req_c = rc; v.e.lv_c = lv; v.e.mis_c = mis; v.e.err_c = err;
    v.e.ld = ld; v.e.baddr = ba; v.e.we = we; v.e.strb = strb; v.e.wdata = wd;
    return v;
  endfunction

  // Reference: outcome of one access from the architectural rules
  function automatic exp_t model(input vec_t v, input logic [31:0] prev_ld);
    exp_t e;
    bit rd_only = v.rd && !v.wr;
    bit wr_only = v.wr && !v.rd;
    int t = rd_only ? int'(v.lt) : int'(v.st);
    int nbytes = 1 << (t % 4);
    bit legal = rd_only ? (t == 0 || t == 1 || t == 2 || t == 4 || t == 5)
                        : (wr_only && t <= 2);
    bit ok = legal && (v.addr % nbytes == 0);
    bit acked = v.dly >= 1 && v.dly <= TO;
    int busy = acked ? v.dly : TO;
    int lane = int'(v.addr % 4);
    logic [7:0]  b = 8'(v.rdata >> (8 * lane));
    logic [15:0] h = 16'(v.rdata >> (16 * (lane / 2)));
    e = '{default: 0};
    e.ld = prev_ld;
    if (!ok) begin
      e.mis_c = (v.rd || v.wr) ? 1 : 0;
      return e;
    end
    e.stall_c = 1 + busy;
    e.req_c   = busy;
    e.err_c   = acked ? 0 : 1;
    e.lv_c    = (rd_only && acked) ? 1 : 0;
    e.baddr   = v.addr - 32'(lane);
    e.we      = wr_only;
    if (!acked) e.ld = 32'h0;
    else if (rd_only)
      case (t)
        0: e.ld = 32'($signed(b));
        1: e.ld = 32'($signed(h));
        4: e.ld = {24'h0, b};
        5: e.ld = {16'h0, h};
        default: e.ld = v.rdata;
      endcase
    if (wr_only) begin
      e.strb  = (nbytes == 1) ? 4'(1 << lane) : (nbytes == 2) ? 4'(3 << (lane & 2)) : 4'hF;
      e.wdata = (nbytes == 1) ? v.data[7:0] * 32'h01010101
              : (nbytes == 2) ? v.data[15:0] * 32'h00010001 : v.data;
    end
    return e;
  endfunction

  // Present one instruction, hold it while stalled, play the memory side
  task automatic run_access(input vec_t v, output exp_t o);
    bit free_seen = 0;
    int post = 0;
    o = '{default: 0};
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; load_type = v.lt; store_type = v.st;
    addr = v.addr; store_data = v.data; bus_ack = 1'b0;
    for (int cyc = 0; cyc < 40 && post < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (free_seen) begin
        mem_read = 1'b0; mem_write = 1'b0; post++;
      end
      #1;
      if (stall) o.stall_c++;
      if (bus_req) begin
        o.req_c++; o.baddr = bus_addr; o.we = bus_we; o.strb = bus_wstrb; o.wdata = bus_wdata;
      end
      if (load_valid) o.lv_c++;
      if (misaligned) o.mis_c++;
      if (bus_error) o.err_c++;
      bus_ack = bus_req && v.dly != 0 && o.req_c == v.dly;
      bus_rdata = bus_ack ? v.rdata : $urandom;
      if (!stall) free_seen = 1;
    end
    if (post < 3) begin
      n_cmp++; n_err++;
      $display("FAIL access_bound: stall never released within 40 cycles");
    end
    bus_ack = 1'b0;
    o.ld = load_data;
  endtask

  task automatic compare(input string tag, input exp_t e, input exp_t o);
    chk({tag, ".stall_cycles"}, o.stall_c, e.stall_c);
    chk({tag, ".req_cycles"}, o.req_c, e.req_c);
    chk({tag, ".load_valid"}, o.lv_c, e.lv_c);
    chk({tag, ".misaligned"}, o.mis_c, e.mis_c);
    chk({tag, ".bus_error"}, o.err_c, e.err_c);
    chk({tag, ".load_data"}, o.ld, e.ld);
    if (e.req_c > 0) begin
      chk({tag, ".bus_addr"}, o.baddr, e.baddr);
      chk({tag, ".bus_we"}, {31'h0, o.we}, {31'h0, e.we});
      chk({tag, ".bus_wstrb"}, {28'h0, o.strb}, {28'h0, e.strb});
      if (e.we) chk({tag, ".bus_wdata"}, o.wdata, e.wdata);
    end
  endtask

  vec_t tbl[14];
  vec_t v;
  exp_t o, e;
  logic [31:0] prev_ld;

  initial begin
    //            rd wr lt st addr          data          rdata        dly  st rq lv ms er ld            baddr         we strb   wdata
    tbl[0]  = mk(0, 1, 0, 2, 32'h100, 32'hDEADBEEF, 32'h0,        3,   4, 3, 0, 0, 0, 32'h0,        32'h100, 1, 4'hF, 32'hDEADBEEF);
    tbl[1]  = mk(1, 0, 0, 0, 32'h203, 32'h0,        32'h80123456, 1,   2, 1, 1, 0, 0, 32'hFFFFFF80, 32'h200, 0, 4'h0, 32'h0);
    tbl[2]  = mk(1, 0, 4, 0, 32'h203, 32'h0,        32'h80123456, 1,   2, 1, 1, 0, 0, 32'h00000080, 32'h200, 0, 4'h0, 32'h0);
    tbl[3]  = mk(0, 1, 0, 1, 32'h12,  32'h0000ABCD, 32'h0,        2,   3, 2, 0, 0, 0, 32'h00000080, 32'h10,  1, 4'hC, 32'hABCDABCD);
    tbl[4]  = mk(1, 0, 5, 0, 32'h12,  32'h0,        32'hABCD1234, 1,   2, 1, 1, 0, 0, 32'h0000ABCD, 32'h10,  0, 4'h0, 32'h0);
    tbl[5]  = mk(1, 0, 2, 0, 32'h101, 32'h0,        32'h0,        1,   0, 0, 0, 1, 0, 32'h0000ABCD, 32'h0,   0, 4'h0, 32'h0);
    tbl[6]  = mk(1, 0, 3, 0, 32'h100, 32'h0,        32'h0,        1,   0, 0, 0, 1, 0, 32'h0000ABCD, 32'h0,   0, 4'h0, 32'h0);
    tbl[7]  = mk(1, 0, 2, 0, 32'h104, 32'h0,        32'hCAFEF00D, 0,   5, 4, 0, 0, 1, 32'h0,        32'h104, 0, 4'h0, 32'h0);
    tbl[8]  = mk(1, 0, 1, 0, 32'h202, 32'h0,        32'h80017FFF, 4,   5, 4, 1, 0, 0, 32'hFFFF8001, 32'h200, 0, 4'h0, 32'h0);
    tbl[9]  = mk(0, 1, 0, 0, 32'h33,  32'h000000A5, 32'h0,        1,   2, 1, 0, 0, 0, 32'hFFFF8001, 32'h30,  1, 4'h8, 32'hA5A5A5A5);
    tbl[10] = mk(1, 1, 2, 2, 32'h0,   32'h0,        32'h0,        1,   0, 0, 0, 1, 0, 32'hFFFF8001, 32'h0,   0, 4'h0, 32'h0);
    tbl[11] = mk(0, 1, 0, 3, 32'h0,   32'h0,        32'h0,        1,   0, 0, 0, 1, 0, 32'hFFFF8001, 32'h0,   0, 4'h0, 32'h0);
    tbl[12] = mk(1, 0, 2, 0, 32'h8,   32'h0,        32'h12345678, 5,   5, 4, 0, 0, 1, 32'h0,        32'h8,   0, 4'h0, 32'h0);
    tbl[13] = mk(1, 0, 2, 0, 32'h8,   32'h0,        32'h12345678, 1,   2, 1, 1, 0, 0, 32'h12345678, 32'h8,   0, 4'h0, 32'h0);

    // Reset values
    #12;
    chk("rst.bus_req", {31'h0, bus_req}, 32'h0);
    chk("rst.stall", {31'h0, stall}, 32'h0);
    chk("rst.load_data", load_data, 32'h0);
    chk("rst.flags", {28'h0, load_valid, misaligned, bus_error, bus_we}, 32'h0);
    chk("rst.bus_addr", bus_addr, 32'h0);
    chk("rst.bus_wdata", {bus_wdata[31:4], bus_wstrb}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_access(tbl[i], o);
      compare($sformatf("vec%0d", i), tbl[i].e, o);
    end
    prev_ld = tbl[13].e.ld;

    // Stray ack while idle must be ignored
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h5A5A5A5A;
    @(negedge clk); #1;
    chk("stray.load_valid", {31'h0, load_valid}, 32'h0);
    chk("stray.bus_req", {31'h0, bus_req}, 32'h0);
    bus_ack = 1'b0;
    @(negedge clk); #1;
    chk("stray.load_data", load_data, prev_ld);

    // Reset in the middle of a bus access
    @(negedge clk);
    mem_read = 1'b1; load_type = 3'b010; addr = 32'h40;
    @(negedge clk); #1;
    chk("midrst.busy_req", {31'h0, bus_req}, 32'h1);
    @(negedge clk); #2;
    mem_read = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst.bus_req", {31'h0, bus_req}, 32'h0);
    chk("midrst.stall", {31'h0, stall}, 32'h0);
    chk("midrst.load_data", load_data, 32'h0);
    chk("midrst.bus_addr", bus_addr, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    prev_ld = 32'h0;
    v = mk(1, 0, 2, 0, 32'h44, 32'h0, 32'h0BADF00D, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e = model(v, prev_ld);
    run_access(v, o);
    compare("postrst", e, o);
    prev_ld = e.ld;

    // Randomized accesses against the reference model
    for (int i = 0; i < 150; i++) begin
      int sel = $urandom_range(0, 9);
      v.rd    = (sel <= 5);
      v.wr    = (sel == 0) || (sel >= 6);
      v.lt    = 3'($urandom_range(0, 7));
      v.st    = 3'($urandom_range(0, 3));
      v.addr  = $urandom;
      v.data  = $urandom;
      v.rdata = $urandom;
      v.dly   = $urandom_range(0, 5);
      e = model(v, prev_ld);
      run_access(v, o);
      compare($sformatf("rnd%0d", i), e, o);
      prev_ld = e.ld;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
